// File: rtl/line_buffer.sv
// Sliding vertical-column generator: presents KernelWidth rows of the same image column per beat,
// backed by KernelWidth-1 line memories and a single registered output stage.
module line_buffer #(
  parameter int unsigned WidthIn     = 1,
  parameter int unsigned KernelWidth = 3,
  parameter int unsigned LineWidth   = 640,
  parameter int unsigned FrameHeight = 480
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [WidthIn-1:0]                  data_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [KernelWidth-1:0][WidthIn-1:0] row_buffers_o,
  output logic                                window_valid_o
);

  localparam int unsigned ColW   = (LineWidth > 1) ? $clog2(LineWidth) : 1;
  localparam int unsigned RowW   = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;
  localparam int unsigned NumMem = KernelWidth - 1;

  logic [ColW-1:0]                      col_q, col_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic                                 valid_q;
  logic                                 window_q, window_d;
  logic [KernelWidth-1:0][WidthIn-1:0]  column_q, column_d;
  logic [NumMem-1:0][WidthIn-1:0]       mem_rd;
  logic                                 in_fire;
  logic                                 col_wrap;

  assign valid_o        = valid_q;
  assign ready_o        = ~valid_q | ready_i;
  assign in_fire        = valid_i & ready_o;
  assign row_buffers_o  = column_q;
  assign window_valid_o = window_q;

  // Each line memory shifts its read value into the next one, so memory k holds line row-k-1.
  for (genvar m = 0; m < NumMem; m++) begin : g_line
    logic [WidthIn-1:0] mem_q [LineWidth];
    logic [WidthIn-1:0] wr_data;

    if (m == 0) begin : g_first
      assign wr_data = data_i;
    end else begin : g_chain
      assign wr_data = mem_rd[m-1];
    end

    assign mem_rd[m] = mem_q[col_q];

    always_ff @(posedge clk_i) begin
      if (in_fire && rst_i) begin
        mem_q[col_q] <= wr_data;
      end
    end
  end

  always_comb begin
    col_wrap = (col_q == ColW'(LineWidth - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (in_fire) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == RowW'(FrameHeight - 1)) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Lines not yet written in this frame read as zero, whatever stale data the RAM holds.
  always_comb begin
    column_d    = '0;
    column_d[0] = data_i;
    for (int k = 1; k < int'(KernelWidth); k++) begin
      column_d[k] = (int'(row_q) < k) ? '0 : mem_rd[k-1];
    end
    window_d = (int'(row_q) >= int'(KernelWidth) - 1) && (int'(col_q) >= int'(KernelWidth) - 1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      window_q <= 1'b0;
      column_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (in_fire) begin
        valid_q  <= 1'b1;
        column_q <= column_d;
        window_q <= window_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Directed and randomised checks of line_buffer with a 3x4x4 frame of 8-bit pixels.
module tb_line_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned K  = 3;
  localparam int unsigned LW = 4;
  localparam int unsigned FH = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                valid_i;
  logic                ready_o;
  logic [W-1:0]        data_i;
  logic                valid_o;
  logic                ready_i;
  logic [K-1:0][W-1:0] row_buffers_o;
  logic                window_valid_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  hist [FH][LW];
  int          mrow = 0;
  int          mcol = 0;
  int          n_acc = 0;
  logic [31:0] sb_q [$];

  line_buffer #(
    .WidthIn    (W),
    .KernelWidth(K),
    .LineWidth  (LW),
    .FrameHeight(FH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .row_buffers_o (row_buffers_o),
    .window_valid_o(window_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_out();
    return {7'd0, window_valid_o, row_buffers_o};
  endfunction

  // Reference: column from stored frame history, zero above the top of the frame.
  task automatic model_push(input logic [7:0] d);
    logic [31:0] e;
    e      = '0;
    e[7:0] = d;
    for (int k = 1; k < int'(K); k++) begin
      if (mrow >= k) e[k*8 +: 8] = hist[mrow-k][mcol];
    end
    e[24] = (mrow >= int'(K) - 1) && (mcol >= int'(K) - 1);
    sb_q.push_back(e);
    hist[mrow][mcol] = d;
    n_acc++;
    if (mcol == int'(LW) - 1) begin
      mcol = 0;
      mrow = (mrow == int'(FH) - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic acc, ofire;
    @(negedge clk_i);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
    acc   = valid_i & ready_o;
    ofire = valid_o & ready_i;
    if (ofire) begin
      check_eq("sb_has_beat", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) check_eq("beat", cur_out(), sb_q.pop_front());
    end
    if (acc) model_push(d);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check_eq({tag, "_out"}, cur_out(), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    mrow  = 0;
    mcol  = 0;
    n_acc = 0;
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;

    do_reset("rst0");
    step(1'b0, 8'd0, 1'b0);
    check_eq("ready_after_rst", {31'd0, ready_o}, 32'd1);
    check_eq("valid_after_rst", {31'd0, valid_o}, 32'd0);

    // Continuous streaming through one frame and into the next.
    for (int p = 1; p <= 20; p++) begin
      step(1'b1, 8'(p), 1'b1);
      check_eq("stream_valid", {31'd0, valid_o}, 32'd1);
      if (p == 1)  check_eq("px1", cur_out(), 32'h0000_0001);
      if (p == 6)  check_eq("px6", cur_out(), 32'h0000_0206);
      if (p == 10) check_eq("px10_wv", {31'd0, window_valid_o}, 32'd0);
      if (p == 11) check_eq("px11", cur_out(), 32'h0103_070B);
      if (p == 17) check_eq("px17_wrap", cur_out(), 32'h0000_0011);
    end
    step(1'b0, 8'd0, 1'b1);
    check_eq("drain_valid", {31'd0, valid_o}, 32'd0);

    // Backpressure after pixel 5.
    do_reset("rst1");
    for (int p = 1; p <= 5; p++) step(1'b1, 8'(p), 1'b1);
    check_eq("px5", cur_out(), 32'h0000_0105);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd6, 1'b0);
      check_eq("stall_ready", {31'd0, ready_o}, 32'd0);
      check_eq("stall_valid", {31'd0, valid_o}, 32'd1);
      check_eq("stall_hold", cur_out(), 32'h0000_0105);
    end
    step(1'b1, 8'd6, 1'b1);
    check_eq("px6_after_stall", cur_out(), 32'h0000_0206);
    step(1'b0, 8'd0, 1'b1);

    // Reset in the middle of a frame.
    do_reset("rst2");
    for (int p = 1; p <= 7; p++) step(1'b1, 8'(p), 1'b1);
    do_reset("rst_mid");
    step(1'b1, 8'd99, 1'b1);
    check_eq("px99", cur_out(), 32'h0000_0063);
    step(1'b0, 8'd0, 1'b1);

    // Random handshakes over three frames.
    do_reset("rst3");
    for (int c = 0; c < 2000 && n_acc < 48; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    check_eq("rand_accepted", 32'(n_acc), 32'd48);
    check_eq("rand_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
